// File: rtl/bsg_manycore_vcache_dma_wh_concentrator_if.sv
// Bundle of handshake/data signals between the vcache DMA channels, the
// wormhole router P port and the concentrator.
//   in_*   : forward flits from num_in_p channels (valid/ready_and)
//   out_*  : concentrated forward flit toward the router
//   ret_*  : return flit from the router and its per-channel fan-out
//   err_o  : sticky flag for dropped return packets with an illegal cid
// modport master = environment (channels + router), slave = concentrator.
interface bsg_manycore_vcache_dma_wh_concentrator_if #(
  parameter int num_in_p     = 2,
  parameter int flit_width_p = 32
);
  logic [num_in_p*flit_width_p-1:0] in_data_i;
  logic [num_in_p-1:0]              in_v_i;
  logic [num_in_p-1:0]              in_ready_and_o;
  logic [flit_width_p-1:0]          out_data_o;
  logic                             out_v_o;
  logic                             out_ready_and_i;
  logic [flit_width_p-1:0]          ret_data_i;
  logic                             ret_v_i;
  logic                             ret_ready_and_o;
  logic [num_in_p*flit_width_p-1:0] ret_data_o;
  logic [num_in_p-1:0]              ret_v_o;
  logic [num_in_p-1:0]              ret_ready_and_i;
  logic                             err_o;

  modport master (
    output in_data_i, in_v_i, out_ready_and_i, ret_data_i, ret_v_i, ret_ready_and_i,
    input  in_ready_and_o, out_data_o, out_v_o, ret_ready_and_o, ret_data_o, ret_v_o, err_o
  );

  modport slave (
    input  in_data_i, in_v_i, out_ready_and_i, ret_data_i, ret_v_i, ret_ready_and_i,
    output in_ready_and_o, out_data_o, out_v_o, ret_ready_and_o, ret_data_o, ret_v_o, err_o
  );
endinterface

// File: rtl/bsg_manycore_vcache_dma_wh_concentrator.sv
// Concentrates num_in_p vcache DMA wormhole channels onto one wormhole link
// and steers return packets back to the channel named by the header cid.
// Ports:
//   clk_i      clock
//   reset_n_i  asynchronous active-low reset
//   link       slave side of the concentrator interface (forward, return, err)
// Forward: round-robin grant among valid headers, locked to the winner until
// its last body flit; header cid optionally stamped with the channel index.
// Return: cid demux with a sink path (and sticky err) for cid >= num_in_p.
// Zero latency on both paths; only FSM state, counters and pointers are stored.
module bsg_manycore_vcache_dma_wh_concentrator #(
  parameter int num_in_p     = 2,
  parameter int flit_width_p = 32,
  parameter int cord_width_p = 8,
  parameter int len_width_p  = 4,
  parameter int cid_width_p  = 2,
  parameter int stamp_cid_p  = 1
) (
  input logic clk_i,
  input logic reset_n_i,
  bsg_manycore_vcache_dma_wh_concentrator_if.slave link
);
  localparam int lg_lp      = (num_in_p > 1) ? $clog2(num_in_p) : 1;
  localparam int len_lsb_lp = cord_width_p;
  localparam int cid_lsb_lp = cord_width_p + len_width_p;

  localparam logic [0:0] f_idle_lp = 1'b0;
  localparam logic [0:0] f_busy_lp = 1'b1;
  localparam logic [1:0] r_idle_lp = 2'd0;
  localparam logic [1:0] r_busy_lp = 2'd1;
  localparam logic [1:0] r_drop_lp = 2'd2;

  logic [flit_width_p-1:0] in_flit [num_in_p];

  genvar gi;
  generate
    for (gi = 0; gi < num_in_p; gi++) begin : g_ch
      assign in_flit[gi] = link.in_data_i[gi*flit_width_p +: flit_width_p];
      // Return flit is broadcast; only ret_v_o selects the destination.
      assign link.ret_data_o[gi*flit_width_p +: flit_width_p] = link.ret_data_i;
    end
  endgenerate

  // ---------------- forward path ----------------
  logic [0:0]             fstate_reg;
  logic [len_width_p-1:0] fcnt_reg;
  logic [lg_lp-1:0]       lock_reg, rr_reg;
  logic [lg_lp-1:0]       grant, sel;
  logic [lg_lp:0]         idx;
  logic                   any_v, f_fire;
  logic [flit_width_p-1:0] out_flit;

  // Scan downward so the lowest offset from rr_reg is the last (winning) hit.
  always_comb begin
    grant = rr_reg;
    any_v = 1'b0;
    idx   = '0;
    for (int i = num_in_p-1; i >= 0; i--) begin
      idx = {1'b0, rr_reg} + (lg_lp+1)'(i);
      if (idx >= (lg_lp+1)'(num_in_p)) idx = idx - (lg_lp+1)'(num_in_p);
      if (link.in_v_i[idx[lg_lp-1:0]]) begin
        grant = idx[lg_lp-1:0];
        any_v = 1'b1;
      end
    end
  end

  assign sel = (fstate_reg == f_busy_lp) ? lock_reg : grant;

  always_comb begin
    out_flit = in_flit[sel];
    // Only headers (IDLE) are stamped; body flits pass untouched.
    if (stamp_cid_p != 0 && fstate_reg == f_idle_lp)
      out_flit[cid_lsb_lp +: lg_lp] = grant;
  end

  always_comb begin
    link.in_ready_and_o = '0;
    if (reset_n_i && (fstate_reg == f_busy_lp || any_v))
      link.in_ready_and_o[sel] = link.out_ready_and_i;
  end

  assign link.out_data_o = out_flit;
  assign link.out_v_o    = reset_n_i &
                           ((fstate_reg == f_busy_lp) ? link.in_v_i[lock_reg] : any_v);
  assign f_fire          = link.out_v_o & link.out_ready_and_i;

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      fstate_reg <= f_idle_lp;
      fcnt_reg   <= '0;
      lock_reg   <= '0;
      rr_reg     <= '0;
    end else if (f_fire) begin
      if (fstate_reg == f_idle_lp) begin
        rr_reg <= (grant == lg_lp'(num_in_p-1)) ? '0 : grant + 1'b1;
        if (out_flit[len_lsb_lp +: len_width_p] != '0) begin
          fstate_reg <= f_busy_lp;
          fcnt_reg   <= out_flit[len_lsb_lp +: len_width_p];
          lock_reg   <= grant;
        end
      end else begin
        fcnt_reg <= fcnt_reg - 1'b1;
        if (fcnt_reg == len_width_p'(1)) fstate_reg <= f_idle_lp;
      end
    end
  end

  // ---------------- return path ----------------
  logic [1:0]             rstate_reg;
  logic [len_width_p-1:0] rcnt_reg;
  logic [cid_width_p-1:0] rdest_reg, hdr_cid, dest;
  logic [len_width_p-1:0] hdr_len;
  logic                   drop, r_fire, err_reg;

  assign hdr_cid = link.ret_data_i[cid_lsb_lp +: cid_width_p];
  assign hdr_len = link.ret_data_i[len_lsb_lp +: len_width_p];

  always_comb begin
    if (rstate_reg == r_idle_lp) begin
      dest = hdr_cid;
      // Widen by one bit so num_in_p == 2^cid_width_p does not truncate to 0.
      drop = ({1'b0, hdr_cid} >= (cid_width_p+1)'(num_in_p));
    end else begin
      dest = rdest_reg;
      drop = (rstate_reg == r_drop_lp);
    end
  end

  always_comb begin
    link.ret_v_o         = '0;
    link.ret_ready_and_o = 1'b0;
    if (reset_n_i) begin
      if (drop) begin
        link.ret_ready_and_o = 1'b1;
      end else begin
        for (int i = 0; i < num_in_p; i++) begin
          if (dest == cid_width_p'(i)) begin
            link.ret_v_o[i]      = link.ret_v_i;
            link.ret_ready_and_o = link.ret_ready_and_i[i];
          end
        end
      end
    end
  end

  assign r_fire     = link.ret_v_i & link.ret_ready_and_o;
  assign link.err_o = err_reg;

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      rstate_reg <= r_idle_lp;
      rcnt_reg   <= '0;
      rdest_reg  <= '0;
      err_reg    <= 1'b0;
    end else if (r_fire) begin
      if (drop) err_reg <= 1'b1;
      if (rstate_reg == r_idle_lp) begin
        if (hdr_len != '0) begin
          rstate_reg <= drop ? r_drop_lp : r_busy_lp;
          rcnt_reg   <= hdr_len;
          rdest_reg  <= hdr_cid;
        end
      end else begin
        rcnt_reg <= rcnt_reg - 1'b1;
        if (rcnt_reg == len_width_p'(1)) rstate_reg <= r_idle_lp;
      end
    end
  end
endmodule

// File: tb/tb_bsg_manycore_vcache_dma_wh_concentrator.sv
module tb_bsg_manycore_vcache_dma_wh_concentrator;
  localparam int N = 2;
  localparam int W = 32;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  bsg_manycore_vcache_dma_wh_concentrator_if #(.num_in_p(N), .flit_width_p(W)) bus ();

  bsg_manycore_vcache_dma_wh_concentrator #(
    .num_in_p(N), .flit_width_p(W), .cord_width_p(8), .len_width_p(4),
    .cid_width_p(2), .stamp_cid_p(1)
  ) dut (
    .clk_i(clk),
    .reset_n_i(rst_n),
    .link(bus)
  );

  int checks = 0;
  int passes = 0;
  int cyc = 0;

  logic [W-1:0] fq [N][$];
  logic [W-1:0] ret_q [$];
  logic [W-1:0] out_log [$];
  int           out_cyc [$];
  logic [63:0]  ret_log [$];
  logic         out_rdy = 1'b1;
  logic [N-1:0] ret_rdy = '1;

  // Reference model state: packet owner (-1 = between packets), flits left,
  // last granted channel; return mode 0 idle / 1 deliver / 2 sink.
  int f_owner = -1, f_left = 0, f_last = N-1;
  int r_mode = 0, r_dest = 0, r_left = 0;
  bit m_err = 1'b0;

  function automatic logic [W-1:0] mk_hdr(input int cid, input int len, input int cord);
    logic [W-1:0] h;
    h = 32'h5A00_0000;
    h[13:12] = cid[1:0];
    h[11:8]  = len[3:0];
    h[7:0]   = cord[7:0];
    return h;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic apply();
    for (int c = 0; c < N; c++) begin
      bus.in_v_i[c] = (fq[c].size() != 0);
      bus.in_data_i[c*W +: W] = (fq[c].size() != 0) ? fq[c][0] : '0;
    end
    bus.ret_v_i         = (ret_q.size() != 0);
    bus.ret_data_i      = (ret_q.size() != 0) ? ret_q[0] : '0;
    bus.out_ready_and_i = out_rdy;
    bus.ret_ready_and_i = ret_rdy;
  endtask

  // Called just after a posedge; advances one cycle and pops consumed flits.
  task automatic step();
    logic [N-1:0] ff;
    logic         fr;
    @(negedge clk);
    ff = bus.in_v_i & bus.in_ready_and_o;
    fr = bus.ret_v_i & bus.ret_ready_and_o;
    @(posedge clk);
    #1;
    for (int c = 0; c < N; c++) if (ff[c]) void'(fq[c].pop_front());
    if (fr) void'(ret_q.pop_front());
    apply();
  endtask

  function automatic int pending();
    return fq[0].size() + fq[1].size() + ret_q.size();
  endfunction

  task automatic run(input int maxc, output int used);
    used = 0;
    while (pending() != 0 && used < maxc) begin
      step();
      used++;
    end
    if (used >= maxc) chk("drain_timeout", 64'(pending()), 64'd0);
  endtask

  // Per-cycle compare against the model; also advances the model.
  task automatic cmp();
    int c;
    logic [W-1:0] ed, rd;
    logic ev, erdy, drp;
    logic [N-1:0] er, erv;
    int d, ln;
    if (!rst_n) begin
      chk("rst_out_v", 64'(bus.out_v_o), 64'd0);
      chk("rst_in_ready", 64'(bus.in_ready_and_o), 64'd0);
      chk("rst_ret_v", 64'(bus.ret_v_o), 64'd0);
      chk("rst_ret_ready", 64'(bus.ret_ready_and_o), 64'd0);
      chk("rst_err", 64'(bus.err_o), 64'd0);
      f_owner = -1; f_left = 0; f_last = N-1;
      r_mode = 0; r_dest = 0; r_left = 0; m_err = 1'b0;
      return;
    end
    cyc++;
    // forward
    c = -1; ev = 1'b0; ed = '0; er = '0;
    if (f_owner >= 0) begin
      c  = f_owner;
      ev = bus.in_v_i[c];
      ed = bus.in_data_i[c*W +: W];
    end else begin
      for (int k = 1; k <= N; k++) begin
        int j;
        j = (f_last + k) % N;
        if (c < 0 && bus.in_v_i[j]) c = j;
      end
      if (c >= 0) begin
        ev = 1'b1;
        ed = bus.in_data_i[c*W +: W];
        ed[12] = c[0];
      end
    end
    if (c >= 0) er[c] = bus.out_ready_and_i;
    chk("out_v", 64'(bus.out_v_o), 64'(ev));
    chk("in_ready", 64'(bus.in_ready_and_o), 64'(er));
    if (ev) chk("out_data", 64'(bus.out_data_o), 64'(ed));
    if (ev && bus.out_ready_and_i) begin
      $display("fwd  cyc=%0d ch=%0d data=%h", cyc, c, bus.out_data_o);
      out_log.push_back(bus.out_data_o);
      out_cyc.push_back(cyc);
      if (f_owner < 0) begin
        f_last = c;
        ln = int'(ed[11:8]);
        if (ln != 0) begin f_owner = c; f_left = ln; end
      end else begin
        f_left--;
        if (f_left == 0) f_owner = -1;
      end
    end
    // return
    rd = bus.ret_data_i;
    if (r_mode == 0) begin d = int'(rd[13:12]); drp = (d >= N); end
    else begin d = r_dest; drp = (r_mode == 2); end
    erv = '0;
    erdy = 1'b1;
    if (!drp) begin
      erv[d] = bus.ret_v_i;
      erdy = bus.ret_ready_and_i[d];
    end
    chk("ret_v", 64'(bus.ret_v_o), 64'(erv));
    chk("ret_ready", 64'(bus.ret_ready_and_o), 64'(erdy));
    chk("ret_data", 64'(bus.ret_data_o), {rd, rd});
    chk("err", 64'(bus.err_o), 64'(m_err));
    if (bus.ret_v_i && erdy) begin
      $display("ret  cyc=%0d dest=%0d drop=%0d data=%h", cyc, d, drp, rd);
      if (drp) m_err = 1'b1;
      else ret_log.push_back({32'(d), rd});
      if (r_mode == 0) begin
        ln = int'(rd[11:8]);
        if (ln != 0) begin r_mode = drp ? 2 : 1; r_dest = d; r_left = ln; end
      end else begin
        r_left--;
        if (r_left == 0) r_mode = 0;
      end
    end
  endtask

  always @(negedge clk) cmp();

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int used;
    bus.in_v_i = '0; bus.in_data_i = '0; bus.ret_v_i = 1'b0; bus.ret_data_i = '0;
    bus.out_ready_and_i = 1'b1; bus.ret_ready_and_i = '1;

    // Reset with both channels valid; then packet locking.
    fq[0].push_back(mk_hdr(0, 3, 8'h11));
    fq[0].push_back(32'h0B0D_0001);
    fq[0].push_back(32'h0B0D_0002);
    fq[0].push_back(32'h0B0D_0003);
    fq[1].push_back(mk_hdr(0, 0, 8'h22));
    apply();
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_out_v_lit", 64'(bus.out_v_o), 64'd0);
    chk("reset_in_ready_lit", 64'(bus.in_ready_and_o), 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    #1;
    chk("first_grant_ch0", 64'(bus.in_ready_and_o), 64'b01);
    run(20, used);
    chk("lock_count", 64'(out_log.size()), 64'd5);
    chk("lock_hdr0", 64'(out_log[0]), 64'(mk_hdr(0, 3, 8'h11)));
    chk("lock_body3", 64'(out_log[3]), 64'h0B0D_0003);
    chk("lock_hdr1_stamped", 64'(out_log[4]), 64'(mk_hdr(1, 0, 8'h22)));
    chk("lock_hdr1_5th_cycle", 64'(out_cyc[4] - out_cyc[0]), 64'd4);

    // Round robin with back-to-back len=0 packets: 0,1,0,1,0,1.
    out_log.delete(); out_cyc.delete();
    for (int i = 0; i < 3; i++) begin
      fq[0].push_back(mk_hdr(2, 0, 8'h40 + i));
      fq[1].push_back(mk_hdr(0, 0, 8'h50 + i));
    end
    apply();
    run(20, used);
    chk("rr_count", 64'(out_log.size()), 64'd6);
    chk("rr_cycles", 64'(used), 64'd6);
    for (int k = 0; k < 6; k++) begin
      chk("rr_order", 64'(out_log[k][7:0]), (k % 2) ? 64'(8'h50 + k/2) : 64'(8'h40 + k/2));
      chk("rr_cid", 64'(out_log[k][13:12]), (k % 2) ? 64'd1 : 64'd2);
    end

    // Cid stamp on header only.
    out_log.delete(); out_cyc.delete();
    fq[1].push_back(mk_hdr(0, 2, 8'h33));
    fq[1].push_back(32'hA5A5_0000);
    fq[1].push_back(32'h0000_0000);
    apply();
    run(20, used);
    chk("stamp_hdr", 64'(out_log[0]), 64'(mk_hdr(1, 2, 8'h33)));
    chk("stamp_body0", 64'(out_log[1]), 64'hA5A5_0000);
    chk("stamp_body1", 64'(out_log[2]), 64'h0000_0000);

    // Backpressure mid-body.
    out_log.delete(); out_cyc.delete();
    fq[0].push_back(mk_hdr(0, 3, 8'h44));
    fq[0].push_back(32'h1111_0001);
    fq[0].push_back(32'h1111_0002);
    fq[0].push_back(32'h1111_0003);
    begin
      logic [7:0] pat;
      int i;
      pat = 8'b1100_1011;  // LSB first: 1,1,0,1,0,0,1,1
      i = 0;
      while (pending() != 0 && i < 16) begin
        out_rdy = pat[i % 8];
        apply();
        step();
        i++;
      end
      chk("bp_drained", 64'(pending()), 64'd0);
      chk("bp_cycles", 64'(i), 64'd7);
    end
    out_rdy = 1'b1;
    apply();
    chk("bp_count", 64'(out_log.size()), 64'd4);
    chk("bp_hdr", 64'(out_log[0]), 64'(mk_hdr(0, 3, 8'h44)));
    chk("bp_body1", 64'(out_log[1]), 64'h1111_0001);
    chk("bp_body2", 64'(out_log[2]), 64'h1111_0002);
    chk("bp_body3", 64'(out_log[3]), 64'h1111_0003);

    // Return demux with a stalled destination.
    ret_q.push_back(mk_hdr(1, 2, 8'h77));
    ret_q.push_back(32'hCAFE_0001);
    ret_q.push_back(32'hCAFE_0002);
    ret_rdy = 2'b00;
    apply();
    step();
    step();
    chk("ret_held", 64'(ret_q.size()), 64'd3);
    ret_rdy = 2'b11;
    apply();
    run(20, used);
    chk("ret_count", 64'(ret_log.size()), 64'd3);
    chk("ret_hdr_ch1", ret_log[0], {32'd1, mk_hdr(1, 2, 8'h77)});
    chk("ret_body_ch1", ret_log[2], {32'd1, 32'hCAFE_0002});

    // Drop path (cid 3) concurrent with a forward packet.
    ret_q.push_back(mk_hdr(3, 2, 8'h88));
    ret_q.push_back(32'hDEAD_1000);
    ret_q.push_back(32'hDEAD_1001);
    fq[1].push_back(mk_hdr(1, 1, 8'h66));
    fq[1].push_back(32'h6666_0001);
    ret_rdy = 2'b00;
    apply();
    run(20, used);
    chk("drop_cycles", 64'(used), 64'd3);
    chk("drop_no_delivery", 64'(ret_log.size()), 64'd3);
    chk("drop_err", 64'(bus.err_o), 64'd1);

    // err stays set across a good packet.
    ret_rdy = 2'b11;
    ret_q.push_back(mk_hdr(0, 0, 8'h99));
    apply();
    run(20, used);
    chk("good_after_drop", ret_log[3], {32'd0, mk_hdr(0, 0, 8'h99)});
    chk("err_sticky", 64'(bus.err_o), 64'd1);

    repeat (2) step();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
